// File: rtl/key_debounce_pio.sv
// Debounced push-button PIO with W1C press capture and a maskable level IRQ.
// Optional press counter at address 3 is enabled by KEY_PIO_PRESS_COUNT_EN.
module key_debounce_pio #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_in,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] w_pressedRaw;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_press;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] w_edgeClr;
  logic             w_maskWr;
  logic [31:0]      w_dataWord;
  logic [31:0]      w_maskWord;
  logic [31:0]      w_edgeWord;
  logic [31:0]      w_countWord;
  logic [31:0]      w_readMux;
  logic             w_unusedWdata;

  assign w_pressedRaw = (ACTIVE_LOW != 0) ? ~key_in : key_in;
  assign w_unusedWdata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_pressedRaw;
      r_sync2 <= r_sync1;
    end
  end

  // A channel only accepts a new level after it has disagreed with the
  // stable value for DEBOUNCE_CYCLES consecutive synchronised cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  assign w_press   = w_accept & r_sync2;
  assign w_maskWr  = write && (address == 2'd1);
  assign w_edgeClr = (write && (address == 2'd2)) ? writedata[WIDTH-1:0] : '0;

  // The press term is OR-ed in after the clear so a coincident press survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
      r_edge <= '0;
    end else begin
      if (w_maskWr) begin
        r_mask <= writedata[WIDTH-1:0];
      end
      r_edge <= (r_edge & ~w_edgeClr) | w_press;
    end
  end

  assign irq = |(r_edge & r_mask);

`ifdef KEY_PIO_PRESS_COUNT_EN
  logic [15:0] r_pressCount;
  logic [5:0]  w_pressPop;
  logic [16:0] w_countSum;

  always_comb begin
    w_pressPop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pressPop = w_pressPop + 6'(w_press[i]);
    end
    w_countSum = {1'b0, r_pressCount} + 17'(w_pressPop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pressCount <= '0;
    end else if (write && (address == 2'd3)) begin
      r_pressCount <= '0;
    end else if (w_countSum[16]) begin
      r_pressCount <= 16'hFFFF;
    end else begin
      r_pressCount <= w_countSum[15:0];
    end
  end

  assign w_countWord = {16'h0000, r_pressCount};
`else
  assign w_countWord = 32'h0000_0000;
`endif

  always_comb begin
    w_dataWord = '0;
    w_maskWord = '0;
    w_edgeWord = '0;
    w_dataWord[WIDTH-1:0] = r_stable;
    w_maskWord[WIDTH-1:0] = r_mask;
    w_edgeWord[WIDTH-1:0] = r_edge;
    case (address)
      2'd0:    w_readMux = w_dataWord;
      2'd1:    w_readMux = w_maskWord;
      2'd2:    w_readMux = w_edgeWord;
      default: w_readMux = w_countWord;
    endcase
  end

  // Registered read path; a same-cycle write is not yet visible here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (read) begin
      readdata <= w_readMux;
    end else begin
      readdata <= '0;
    end
  end

endmodule

// File: tb/tb_key_debounce_pio.sv
// Directed self-checking bench for key_debounce_pio (WIDTH=2, DEBOUNCE_CYCLES=4, active-low).
// Builds with or without KEY_PIO_PRESS_COUNT_EN.
module tb_key_debounce_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  key_in;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  key_debounce_pio #(
    .WIDTH(2),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_in(key_in),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    d    = readdata;
    read = 1'b0;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; key_in = 2'b11; read = 1'b0; write = 1'b0;
    address = 2'd0; writedata = '0;
    tick(3);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_readdata: got %0h expected 0", readdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL rst_irq: got %0b expected 0", irq); end
    reset = 1'b0;
    tick(2);
    busRead(2'd0, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL rst_data: got %0h expected 0", rd); end
    busRead(2'd2, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL rst_edge: got %0h expected 0", rd); end
    busRead(2'd1, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL rst_mask: got %0h expected 0", rd); end
    busWrite(2'd0, 32'h3);
    busRead(2'd0, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL data_write_ignored: got %0h expected 0", rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL idle_irq: got %0b expected 0", irq); end
  endtask

  task automatic test_press();
    key_in  = 2'b10;
    address = 2'd0;
    read    = 1'b1;
    tick(6);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL press_early: got %0h expected 0", readdata); end
    tick(1);
    total++; if (readdata !== 32'h1) begin bad++; $display("[TB] FAIL press_latency: got %0h expected 1", readdata); end
    read = 1'b0;
    busRead(2'd2, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL press_edge: got %0h expected 1", rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL press_irq_masked: got %0b expected 0", irq); end
  endtask

  task automatic test_glitch();
    key_in = 2'b00;
    tick(3);
    key_in = 2'b10;
    tick(10);
    busRead(2'd0, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL glitch_data: got %0h expected 1", rd); end
    busRead(2'd2, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL glitch_edge: got %0h expected 1", rd); end
    key_in = 2'b00;
    tick(8);
    key_in = 2'b10;
    tick(12);
    busRead(2'd0, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL long_press_data: got %0h expected 1", rd); end
    busRead(2'd2, rd);
    total++; if (rd !== 32'h3) begin bad++; $display("[TB] FAIL long_press_edge: got %0h expected 3", rd); end
  endtask

  task automatic test_irq();
    busWrite(2'd2, 32'h2);
    busRead(2'd2, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL w1c_bit1: got %0h expected 1", rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_before_mask: got %0b expected 0", irq); end
    busWrite(2'd1, 32'h3);
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_after_mask: got %0b expected 1", irq); end
    busWrite(2'd2, 32'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_after_w1c: got %0b expected 0", irq); end
    key_in = 2'b11;
    tick(12);
    busRead(2'd0, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL release_data: got %0h expected 0", rd); end
    busRead(2'd2, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL release_no_edge: got %0h expected 0", rd); end
    key_in = 2'b10;
    tick(5);
    busWrite(2'd2, 32'h1);
    busRead(2'd2, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL w1c_vs_press: got %0h expected 1", rd); end
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_after_press: got %0b expected 1", irq); end
  endtask

  task automatic test_back_to_back();
    address   = 2'd1;
    writedata = 32'h1;
    read      = 1'b1;
    write     = 1'b1;
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
    total++; if (readdata !== 32'h3) begin bad++; $display("[TB] FAIL rw_same_cycle: got %0h expected 3", readdata); end
    busRead(2'd1, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL rw_new_mask: got %0h expected 1", rd); end
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL rw_irq: got %0b expected 1", irq); end
  endtask

  task automatic test_reset_mid();
    key_in = 2'b00;
    tick(4);
    reset = 1'b1;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL midrst_irq: got %0b expected 0", irq); end
    key_in = 2'b11;
    tick(2);
    reset = 1'b0;
    tick(12);
    busRead(2'd0, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL midrst_data: got %0h expected 0", rd); end
    busRead(2'd2, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL midrst_edge: got %0h expected 0", rd); end
    busRead(2'd1, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL midrst_mask: got %0h expected 0", rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL midrst_irq_after: got %0b expected 0", irq); end
  endtask

  task automatic test_count();
`ifdef KEY_PIO_PRESS_COUNT_EN
    for (int i = 0; i < 3; i++) begin
      key_in = 2'b10;
      tick(8);
      key_in = 2'b11;
      tick(8);
    end
    key_in = 2'b00;
    tick(8);
    key_in = 2'b11;
    tick(8);
    busRead(2'd3, rd);
    total++; if (rd !== 32'h5) begin bad++; $display("[TB] FAIL count_five: got %0h expected 5", rd); end
    force dut.r_pressCount = 16'hFFFF;
    tick(1);
    release dut.r_pressCount;
    key_in = 2'b10;
    tick(8);
    key_in = 2'b11;
    tick(8);
    busRead(2'd3, rd);
    total++; if (rd !== 32'hFFFF) begin bad++; $display("[TB] FAIL count_saturate: got %0h expected ffff", rd); end
    busWrite(2'd3, 32'h0);
    busRead(2'd3, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL count_clear: got %0h expected 0", rd); end
`else
    key_in = 2'b10;
    tick(8);
    key_in = 2'b11;
    tick(8);
    busRead(2'd3, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL addr3_zero: got %0h expected 0", rd); end
    busWrite(2'd3, 32'hFFFF_FFFF);
    busRead(2'd3, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL addr3_write_ignored: got %0h expected 0", rd); end
    busRead(2'd2, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL addr3_edge: got %0h expected 1", rd); end
`endif
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    test_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
